// File: rtl/axis_packer_pkg.sv
// axis_packer_pkg: shared defaults, lane-count helper and lane index type for the result packer.
package axis_packer_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LANE_WIDTH = 8;
    function automatic int lanes_of(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction
    localparam int DEF_LANES = lanes_of(DEF_DATA_WIDTH, DEF_LANE_WIDTH);
    typedef logic [$clog2(DEF_LANES)-1:0] lane_t;
endpackage

// File: rtl/axis_result_packer_if.sv
// axis_result_packer_if: AXI-Stream bundle; tkeep exists only with AXIS_PACKER_TKEEP_EN.
interface axis_result_packer_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] tdata;
    logic tvalid;
    logic tlast;
    logic tready;
`ifdef AXIS_PACKER_TKEEP_EN
    logic [DATA_WIDTH/8-1:0] tkeep;
`endif
    modport master(
`ifdef AXIS_PACKER_TKEEP_EN
        output tkeep,
`endif
        output tdata, tvalid, tlast,
        input tready
    );
    modport slave(
`ifdef AXIS_PACKER_TKEEP_EN
        input tkeep,
`endif
        input tdata, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_out_reg.sv
// axis_out_reg: one-entry registered AXI-Stream output slot with pass-through ready.
// Keep register is built only with AXIS_PACKER_TKEEP_EN.
module axis_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic last,
`ifdef AXIS_PACKER_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0] keep,
`endif
    output logic ready,
    axis_result_packer_if.master m
);
    assign ready = ~m.tvalid | m.tready;
    // load is only asserted when ready, so a reload never overwrites an untaken word
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            m.tdata  <= '0;
            m.tvalid <= 1'b0;
            m.tlast  <= 1'b0;
`ifdef AXIS_PACKER_TKEEP_EN
            m.tkeep  <= '0;
`endif
        end else if (load) begin
            m.tdata  <= data;
            m.tvalid <= 1'b1;
            m.tlast  <= last;
`ifdef AXIS_PACKER_TKEEP_EN
            m.tkeep  <= keep;
`endif
        end else if (m.tready)
            m.tvalid <= 1'b0;
endmodule

// File: rtl/axis_result_packer.sv
// axis_result_packer: packs LANES low-byte results into one word, flushing partial words on TLAST.
// Optional M_AXIS_TKEEP via AXIS_PACKER_TKEEP_EN.
module axis_result_packer
    import axis_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
    input logic ACLK,
    input logic ARESET,
    axis_result_packer_if.slave  s_axis,
    axis_result_packer_if.master m_axis
);
    localparam int LANES = lanes_of(DATA_WIDTH, LANE_WIDTH);
    localparam int LIDX = $clog2(LANES);
    logic [DATA_WIDTH-1:0] acc;
    logic [LIDX-1:0] lane;
    logic [LANE_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] word;
    logic accept, closing, load, ready;
    logic unused_hi;
    assign b = s_axis.tdata[LANE_WIDTH-1:0];
    assign accept = s_axis.tvalid & ready;
    assign closing = (lane == LIDX'(LANES - 1)) | s_axis.tlast;
    assign load = accept & closing;
    // unfilled lanes of acc are always zero, so OR-ing in the new byte is enough
    assign word = acc | (DATA_WIDTH'(b) << (int'(lane) * LANE_WIDTH));
    assign s_axis.tready = ready;
`ifdef AXIS_PACKER_TKEEP_EN
    logic [DATA_WIDTH/8-1:0] keep;
    always_comb begin
        keep = '0;
        for (int k = 0; k < LANES; k++)
            if (k <= int'(lane)) keep[k*(LANE_WIDTH/8) +: LANE_WIDTH/8] = '1;
    end
    assign unused_hi = ^{s_axis.tdata[DATA_WIDTH-1:LANE_WIDTH], s_axis.tkeep};
`else
    assign unused_hi = ^s_axis.tdata[DATA_WIDTH-1:LANE_WIDTH];
`endif
    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            acc  <= '0;
            lane <= '0;
        end else if (accept) begin
            acc  <= closing ? '0 : word;
            lane <= closing ? '0 : lane + 1'b1;
        end
    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk   (ACLK),
        .rst   (ARESET),
        .load  (load),
        .data  (word),
        .last  (s_axis.tlast),
`ifdef AXIS_PACKER_TKEEP_EN
        .keep  (keep),
`endif
        .ready (ready),
        .m     (m_axis)
    );
endmodule

// File: tb/tb_axis_result_packer.sv
// tb_axis_result_packer: scoreboard bench; stimulus pushes expected words, a monitor pops on each output handshake.
module tb_axis_result_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    logic chk_ready = 1'b0;
    typedef struct {
        logic [31:0] data;
        logic last;
        logic [3:0] keep;
    } exp_t;
    exp_t q[$];

    axis_result_packer_if #(.DATA_WIDTH(32)) s_if ();
    axis_result_packer_if #(.DATA_WIDTH(32)) m_if ();

    axis_result_packer dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l, input logic [3:0] k);
        exp_t e;
        e.data = d;
        e.last = l;
        e.keep = k;
        q.push_back(e);
    endtask

    // presents a beat at a falling edge and returns on the falling edge after it is taken
    task automatic beat(input logic [31:0] d, input logic l);
        int n = 0;
        s_if.tdata = d;
        s_if.tlast = l;
        s_if.tvalid = 1'b1;
        #2;
        while (!s_if.tready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL beat_timeout data=%h not accepted within 200 cycles", d);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (chk_ready) chk("s_ready_sustained", 32'(s_if.tready), 32'd1);
            if (m_if.tvalid && m_if.tready && !rst) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word got=%h expected=none", m_if.tdata);
                end else begin
                    e = q.pop_front();
                    chk("out_data", m_if.tdata, e.data);
                    chk("out_last", 32'(m_if.tlast), 32'(e.last));
`ifdef AXIS_PACKER_TKEEP_EN
                    chk("out_keep", 32'(m_if.tkeep), 32'(e.keep));
`endif
                end
            end
        end
    end

    initial begin
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
`ifdef AXIS_PACKER_TKEEP_EN
        s_if.tkeep = '1;
`endif
        m_if.tready = 1'b1;
        #1;
        chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_tdata", m_if.tdata, 32'd0);
        chk("rst_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_s_tready", 32'(s_if.tready), 32'd1);
`ifdef AXIS_PACKER_TKEEP_EN
        chk("rst_tkeep", 32'(m_if.tkeep), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        push(32'h44332211, 1'b1, 4'hF);
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        chk("no_early_valid", 32'(m_if.tvalid), 32'd0);
        beat(32'h44, 1'b1);
        chk("latency_valid", 32'(m_if.tvalid), 32'd1);
        idle();

        push(32'h00007A3C, 1'b1, 4'h3);
        beat(32'h3C, 1'b0);
        beat(32'h7A, 1'b1);
        idle();
        idle();

        push(32'h04030201, 1'b0, 4'hF);
        push(32'h08070605, 1'b1, 4'hF);
        chk_ready = 1'b1;
        for (int i = 1; i <= 8; i++) beat(32'(i), i == 8);
        chk_ready = 1'b0;
        idle();

        m_if.tready = 1'b0;
        push(32'h13121110, 1'b0, 4'hF);
        push(32'h17161514, 1'b0, 4'hF);
        push(32'h1B1A1918, 1'b1, 4'hF);
        fork
            begin
                for (int i = 0; i < 12; i++) beat(32'h10 + 32'(i), i == 11);
                idle();
            end
            begin
                logic [31:0] cap;
                int n = 0;
                @(negedge clk);
                #1;
                while (!m_if.tvalid && n < 100) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("stall_word_seen", 32'(m_if.tvalid), 32'd1);
                cap = m_if.tdata;
                chk("stall_first_word", cap, 32'h13121110);
                repeat (5) begin
                    chk("stall_valid", 32'(m_if.tvalid), 32'd1);
                    chk("stall_data", m_if.tdata, cap);
                    chk("stall_last", 32'(m_if.tlast), 32'd0);
                    chk("stall_s_tready", 32'(s_if.tready), 32'd0);
                    @(negedge clk);
                    #1;
                end
                m_if.tready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);

        beat(32'h55, 1'b0);
        beat(32'h66, 1'b0);
        s_if.tvalid = 1'b0;
        #4;
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("mid_rst_tdata", m_if.tdata, 32'd0);
        chk("mid_rst_tlast", 32'(m_if.tlast), 32'd0);
        chk("mid_rst_s_tready", 32'(s_if.tready), 32'd1);
`ifdef AXIS_PACKER_TKEEP_EN
        chk("mid_rst_tkeep", 32'(m_if.tkeep), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(32'hA3A2A1A0, 1'b1, 4'hF);
        for (int i = 0; i < 4; i++) beat(32'hA0 + 32'(i), i == 3);
        idle();

        push(32'h00000605, 1'b1, 4'h3);
        beat(32'hFFFFFF05, 1'b0);
        beat(32'h00000006, 1'b1);
        idle();

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/axis_result_packer.md
# axis_result_packer

Downstream stage of the matrix-multiplication AXI-Stream coprocessor. It consumes the coprocessor's master stream, where each 32-bit result word carries an 8-bit result in its low byte, and packs LANES consecutive results into one DATA_WIDTH word for the DMA/host side. The output stage is registered. TLAST is honoured so that a partial final word is flushed.

## Interface
- DATA_WIDTH, 32: width of the input and output TDATA.
- LANE_WIDTH, 8: result width; bits taken from the low end of each input beat.
- LANES, DATA_WIDTH/LANE_WIDTH (4): results per output word; must be an integer ≥ 2.
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  DATA_WIDTH  coprocessor result; only [LANE_WIDTH-1:0] is used.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TLAST  in  1  last result of the packet.
- S_AXIS_TREADY  out  1  packer can accept a beat.
- M_AXIS_TDATA  out  DATA_WIDTH  packed word; lane k is at bits [k*LANE_WIDTH +: LANE_WIDTH].
- M_AXIS_TVALID  out  1  packed word valid.
- M_AXIS_TLAST  out  1  word closes the packet.
- M_AXIS_TREADY  in  1  downstream accepts.
- M_AXIS_TKEEP  out  DATA_WIDTH/8  valid-byte mask. Present only with AXIS_PACKER_TKEEP_EN.

## Operation
- Internal state:
  - acc: the partial word, DATA_WIDTH bits.
  - lane: the fill index, 0..LANES-1.
  - A registered output slot: data, valid, last, and keep.
- S_AXIS_TREADY = ~M_AXIS_TVALID | M_AXIS_TREADY. This is combinational, with no dependence on S_AXIS_TDATA or S_AXIS_TLAST.
- An input beat is accepted when S_AXIS_TVALID & S_AXIS_TREADY. On acceptance, byte b = S_AXIS_TDATA[LANE_WIDTH-1:0] goes to lane `lane`, and the upper input bits are discarded.
- Case: not closing, i.e. lane < LANES-1 and TLAST=0.
  - acc[lane] ← b.
  - lane ← lane+1.
  - The output slot is untouched.
- Case: closing, i.e. lane == LANES-1 or TLAST=1.
  - The output slot is loaded with acc | (b << lane*LANE_WIDTH).
  - M_AXIS_TVALID ← 1.
  - M_AXIS_TLAST ← S_AXIS_TLAST.
  - keep ← lanes 0..lane set.
  - acc ← 0 and lane ← 0.
- Unfilled lanes of a flushed partial word are zero.
- Output handshake (M_AXIS_TVALID & M_AXIS_TREADY) with no closing beat in the same cycle: M_AXIS_TVALID ← 0.
- Output handshake and a closing beat in the same cycle: the slot is reloaded, TVALID stays 1, and there is no bubble.
- While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, TDATA, TLAST and TKEEP hold stable.
- FSM view:
  - States:
    - EMPTY: lane=0, slot empty.
    - FILLING: lane>0.
    - FULL: slot valid, with lane 0 or higher.
  - Transitions are as above.
  - A TLAST beat with lane=0 emits a single-lane word.

## Timing
- Reset values, applied while ARESET=1 and asynchronously:
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0.
  - acc=0, lane=0.
- S_AXIS_TREADY is 1 in reset, since it follows from TVALID=0.
- Reset mid-packet discards the partial word and any un-taken output word. The next accepted beat lands in lane 0.
- Latency: M_AXIS_TVALID rises on the edge that accepts the closing beat, so the word is visible one cycle after that beat is presented.
- Throughput: one input beat per cycle sustained when M_AXIS_TREADY=1.

## Configuration
- AXIS_PACKER_TKEEP_EN defined:
  - M_AXIS_TKEEP exists.
  - Each output lane maps to LANE_WIDTH/8 bits of the mask, set for every filled lane.
- Not defined:
  - The port is absent and no keep register is built.
  - Consumers rely on zero fill.

## Structure
- A shared package axis_packer_pkg holds:
  - localparam defaults for DATA_WIDTH and LANE_WIDTH.
  - A LANES helper function.
  - A typedef for the lane index (clog2(LANES) bits).
- The output slot is a natural sub-module, axis_out_reg: a one-entry register with valid/ready, data, last and keep, and a pass-through ready.
- Packing logic stays in the top module.

## Test plan
- Four beats 0x11, 0x22, 0x33, 0x44, TLAST on the 4th, M_AXIS_TREADY=1 → one word 0x44332211, TLAST=1, TKEEP=0xF, valid one cycle after the 4th beat.
- Two beats 0x3C, 0x7A, TLAST on the 2nd → 0x00007A3C, TLAST=1, TKEEP=0x3. Without the macro, only the data and TLAST are checked.
- Eight back-to-back beats 0x01..0x08, TLAST on the 8th → 0x04030201 with TLAST=0, then 0x08070605 with TLAST=1. S_AXIS_TREADY never drops.
- M_AXIS_TREADY held 0 for 5 cycles while a word is pending:
  - S_AXIS_TREADY=0 and the output is stable.
  - After release, no words are lost or duplicated across a 12-beat packet.
- ARESET pulsed after two beats of a packet:
  - All outputs read 0 immediately.
  - A following 4-beat packet 0xA0..0xA3 yields 0xA3A2A1A0.
- Input beat 0xFFFFFF05 followed by 0x00000006 with TLAST → 0x00000605.
